// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux; round-robin, fixed-priority or external-select arbitration with packet locking on last.
// Latency: 1 clock from input handshake to registered output beat (full 1 beat/cycle throughput).
// Backpressure: s_ready_o follows the output-slot load enable; a stalled output beat holds and all inputs see ready low.
module stream_mux_arb #(
  parameter int N_CHANNELS = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CHAN_WIDTH = $clog2(N_CHANNELS)
) (
  input  logic                             clk_i,
  input  logic                             a_rst_n_i,
  input  logic [1:0]                       mode_i,
  input  logic [CHAN_WIDTH-1:0]            select_i,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] s_data_i,
  input  logic [N_CHANNELS-1:0]            s_valid_i,
  input  logic [N_CHANNELS-1:0]            s_last_i,
  output logic [N_CHANNELS-1:0]            s_ready_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic [CHAN_WIDTH-1:0]            m_chan_o,
  output logic                             m_last_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i
);

  localparam logic [1:0]            MODE_RR  = 2'd0;
  localparam logic [1:0]            MODE_EXT = 2'd2;
  // Pointer starts at the top channel so channel 0 is searched first after reset.
  localparam logic [CHAN_WIDTH-1:0] RR_INIT  = CHAN_WIDTH'(N_CHANNELS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CHAN_WIDTH-1:0] grant_q, grant_d;
  logic [CHAN_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CHAN_WIDTH-1:0] m_chan_q, m_chan_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;

  logic                  load;
  logic                  arb_vld;
  logic [CHAN_WIDTH-1:0] arb_chan;
  logic                  srv_vld;
  logic [CHAN_WIDTH-1:0] srv_chan;
  logic                  beat_vld;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  hs;

  // The output slot can take a new beat when empty or being drained this cycle.
  assign load = !m_valid_q || m_ready_i;

  // Combinational winner among valid channels; only used while no packet is locked.
  always_comb begin
    arb_vld  = 1'b0;
    arb_chan = '0;
    case (mode_i)
      MODE_RR: begin
        // Search above the pointer first, then wrap and search from channel 0 up to it.
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (!arb_vld && s_valid_i[k] && (k > int'(rr_ptr_q))) begin
            arb_vld  = 1'b1;
            arb_chan = CHAN_WIDTH'(k);
          end
        end
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (!arb_vld && s_valid_i[k] && (k <= int'(rr_ptr_q))) begin
            arb_vld  = 1'b1;
            arb_chan = CHAN_WIDTH'(k);
          end
        end
      end
      MODE_EXT: begin
        // An out-of-range select matches no channel, so nothing is granted.
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (!arb_vld && s_valid_i[k] && (k == int'(select_i))) begin
            arb_vld  = 1'b1;
            arb_chan = CHAN_WIDTH'(k);
          end
        end
      end
      default: begin
        // Fixed priority (mode 1, and reserved mode 3): lowest index wins.
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (!arb_vld && s_valid_i[k]) begin
            arb_vld  = 1'b1;
            arb_chan = CHAN_WIDTH'(k);
          end
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= RR_INIT;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FSM next state: a non-last beat locks the source, a last beat frees the mux and moves the pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      if (beat_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = srv_chan;
      end else begin
        state_d = ST_LOCKED;
        grant_d = srv_chan;
      end
    end
  end

  // FSM outputs: which channel is served; a locked channel is served regardless of mode/select.
  always_comb begin
    srv_vld  = 1'b0;
    srv_chan = '0;
    case (state_q)
      ST_IDLE: begin
        srv_vld  = arb_vld;
        srv_chan = arb_chan;
      end
      ST_LOCKED: begin
        srv_vld  = 1'b1;
        srv_chan = grant_q;
      end
    endcase
  end

  // Steer ready to the served channel and pick up its beat; ready is forced low while in reset.
  always_comb begin
    s_ready_o = '0;
    beat_vld  = 1'b0;
    beat_last = 1'b0;
    beat_data = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (k == int'(srv_chan)) begin
        s_ready_o[k] = a_rst_n_i && srv_vld && load;
        beat_vld     = s_valid_i[k];
        beat_last    = s_last_i[k];
        beat_data    = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hs = srv_vld && load && beat_vld;

  // Output slot next value: load on handshake, empty when drained, otherwise hold.
  always_comb begin
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (hs) begin
      m_data_d  = beat_data;
      m_chan_d  = srv_chan;
      m_last_d  = beat_last;
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  // Output slot registers; data is not cleared when the slot empties.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      m_data_q  <= '0;
      m_chan_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_chan_o  = m_chan_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;

  // At most one producer is offered the slot in any cycle.
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!a_rst_n_i) $onehot0(s_ready_o));

  // A stalled output beat stays presented and unchanged.
  a_stall_hold: assert property (@(posedge clk_i) disable iff (!a_rst_n_i)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o) && $stable(m_chan_o) && $stable(m_last_o)));

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: bench for stream_mux_arb, one 8x8-bit instance and one 3x32-bit instance.
// Latency: each output beat is expected one clock after its input handshake.
// Backpressure: downstream ready is randomized; producers hold a beat until it is taken.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mode;
  int          sel;
  logic        m_rdy;

  // 8-channel, 8-bit instance
  logic [63:0] a_s_data;
  logic [7:0]  a_s_valid, a_s_last, a_s_ready;
  logic [2:0]  a_sel, a_m_chan;
  logic [7:0]  a_m_data;
  logic        a_m_last, a_m_valid;

  // 3-channel, 32-bit instance
  logic [95:0] b_s_data;
  logic [2:0]  b_s_valid, b_s_last, b_s_ready;
  logic [1:0]  b_sel, b_m_chan;
  logic [31:0] b_m_data;
  logic        b_m_last, b_m_valid;

  stream_mux_arb #(.N_CHANNELS(8), .DATA_WIDTH(8)) dut_a (
    .clk_i(clk), .a_rst_n_i(rst_n), .mode_i(mode), .select_i(a_sel),
    .s_data_i(a_s_data), .s_valid_i(a_s_valid), .s_last_i(a_s_last), .s_ready_o(a_s_ready),
    .m_data_o(a_m_data), .m_chan_o(a_m_chan), .m_last_o(a_m_last), .m_valid_o(a_m_valid),
    .m_ready_i(m_rdy)
  );

  stream_mux_arb #(.N_CHANNELS(3), .DATA_WIDTH(32)) dut_b (
    .clk_i(clk), .a_rst_n_i(rst_n), .mode_i(mode), .select_i(b_sel),
    .s_data_i(b_s_data), .s_valid_i(b_s_valid), .s_last_i(b_s_last), .s_ready_o(b_s_ready),
    .m_data_o(b_m_data), .m_chan_o(b_m_chan), .m_last_o(b_m_last), .m_valid_o(b_m_valid),
    .m_ready_i(m_rdy)
  );

  // Producer beat stores: channel c presents bd/bl[c][head[c]] while show[c] is set.
  logic [31:0] bd [8][512];
  bit          bl [8][512];
  int          head [8];
  int          tail [8];
  bit          show [8];
  int          hold_off [8];

  // Reference model state: locked channel (-1 none), last channel served, output slot.
  int          lock, rr, mc;
  bit          mv, ml;
  logic [31:0] md;
  int          e_pick;
  bit          e_acc;

  bit          phase_b, rand_ctl;
  int          prob, rdy_prob;
  int          total, bad;

  int          log_ch [$];
  bit          log_last [$];
  logic [31:0] log_dat [$];
  logic [7:0]  log_rdy [$];

  logic [7:0]  obs_ready;
  logic        obs_vld, obs_last;
  logic [31:0] obs_dat;
  logic [2:0]  obs_chan;

  always_comb begin
    if (phase_b) begin
      obs_ready = {5'b0, b_s_ready};
      obs_vld   = b_m_valid;
      obs_dat   = b_m_data;
      obs_chan  = {1'b0, b_m_chan};
      obs_last  = b_m_last;
    end else begin
      obs_ready = a_s_ready;
      obs_vld   = a_m_valid;
      obs_dat   = {24'b0, a_m_data};
      obs_chan  = a_m_chan;
      obs_last  = a_m_last;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_beat(input int c, input logic [31:0] d, input bit last);
    bd[c][tail[c]] = d;
    bl[c][tail[c]] = last;
    tail[c]++;
  endtask

  task automatic gen_pkts(input int c, input int min_beats);
    int len;
    while (tail[c] < min_beats) begin
      len = $urandom_range(4, 1);
      for (int j = 0; j < len; j++) add_beat(c, $urandom, j == len - 1);
    end
  endtask

  task automatic clear_prod();
    for (int c = 0; c < 8; c++) begin
      head[c] = 0; tail[c] = 0; show[c] = 1'b0; hold_off[c] = 0;
    end
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_last.delete(); log_dat.delete(); log_rdy.delete();
  endtask

  task automatic mdl_reset();
    lock = -1; rr = (phase_b ? 3 : 8) - 1;
    mv = 1'b0; ml = 1'b0; md = '0; mc = 0;
  endtask

  task automatic drive();
    for (int c = 0; c < 8; c++) begin
      a_s_valid[c]       = !phase_b && show[c];
      a_s_last[c]        = bl[c][head[c]];
      a_s_data[c*8 +: 8] = bd[c][head[c]][7:0];
    end
    for (int c = 0; c < 3; c++) begin
      b_s_valid[c]         = phase_b && show[c];
      b_s_last[c]          = bl[c][head[c]];
      b_s_data[c*32 +: 32] = bd[c][head[c]];
    end
    a_sel = sel[2:0];
    b_sel = sel[1:0];
  endtask

  task automatic offer();
    for (int c = 0; c < 8; c++) begin
      if (hold_off[c] > 0) hold_off[c]--;
      else if (!show[c] && head[c] < tail[c] && $urandom_range(99) < prob) show[c] = 1'b1;
    end
    m_rdy = ($urandom_range(99) < rdy_prob);
  endtask

  task automatic begin_traffic();
    offer();
    drive();
  endtask

  // Predict which channel gets the slot this cycle and compare the DUT against the model.
  task automatic eval_cycle();
    int         n, s;
    bit         stall;
    bit         vv [8];
    logic [7:0] exp_rdy;
    n = phase_b ? 3 : 8;
    s = phase_b ? int'(b_sel) : int'(a_sel);
    for (int c = 0; c < 8; c++) vv[c] = show[c] && (c < n);
    stall  = mv && !m_rdy;
    e_pick = -1;
    if (!stall) begin
      if (lock >= 0) e_pick = lock;
      else if (mode == 2'd2) begin
        if (s < n && vv[s]) e_pick = s;
      end else if (mode == 2'd0) begin
        for (int d = 1; d <= n; d++) if (e_pick < 0 && vv[(rr + d) % n]) e_pick = (rr + d) % n;
      end else begin
        for (int c = 0; c < n; c++) if (e_pick < 0 && vv[c]) e_pick = c;
      end
    end
    exp_rdy = (e_pick >= 0) ? (8'd1 << e_pick) : 8'd0;
    e_acc   = (e_pick >= 0) && vv[e_pick];
    check_val("s_ready", obs_ready, exp_rdy);
    check_val("m_valid", obs_vld, mv);
    check_val("m_data", obs_dat, md);
    check_val("m_chan", obs_chan, mc);
    check_val("m_last", obs_last, ml);
    log_rdy.push_back(obs_ready);
    if (obs_vld && m_rdy) begin
      log_ch.push_back(int'(obs_chan));
      log_last.push_back(obs_last);
      log_dat.push_back(obs_dat);
    end
  endtask

  task automatic commit();
    logic [31:0] mask;
    mask = phase_b ? 32'hFFFF_FFFF : 32'h0000_00FF;
    if (e_acc) begin
      md = bd[e_pick][head[e_pick]] & mask;
      mc = e_pick;
      ml = bl[e_pick][head[e_pick]];
      mv = 1'b1;
      if (ml) begin lock = -1; rr = e_pick; end
      else lock = e_pick;
      head[e_pick]++;
      show[e_pick] = 1'b0;
    end else if (m_rdy) begin
      mv = 1'b0;
    end
    if (rand_ctl) begin
      mode = 2'($urandom_range(3));
      sel  = $urandom_range(7);
    end
    offer();
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic run_n(input int k);
    repeat (k) cycle();
  endtask

  function automatic bit drained();
    for (int c = 0; c < 8; c++) if (head[c] != tail[c]) return 1'b0;
    return !mv;
  endfunction

  task automatic run_drain(input int budget, input string tag);
    int cyc = 0;
    while (!drained() && cyc < budget) begin
      cycle();
      cyc++;
    end
    check_val(tag, drained(), 1);
  endtask

  task automatic finish_reset();
    clear_prod();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_reset();
    clear_logs();
    rand_ctl = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    finish_reset();
  endtask

  // Compare logged output channels against a digit string, e.g. "222251".
  task automatic chk_chans(input string tag, input string seq);
    check_val({tag, "_count"}, log_ch.size() >= seq.len(), 1);
    for (int i = 0; i < seq.len(); i++)
      check_val(tag, (i < log_ch.size()) ? log_ch[i] : -1, int'(seq[i]) - 48);
  endtask

  task automatic lock_test(input logic [1:0] m, input string exp_seq);
    do_reset();
    mode = m; prob = 100; rdy_prob = 100;
    for (int j = 0; j < 4; j++) add_beat(2, 32'h20 + j, j == 3);
    add_beat(1, 32'h11, 1'b1);
    add_beat(5, 32'h55, 1'b1);
    hold_off[1] = 1; hold_off[5] = 1;
    begin_traffic();
    run_drain(100, "lock_drain");
    chk_chans("lock_chan", exp_seq);
    for (int i = 0; i < 6; i++)
      check_val("lock_last", (i < log_last.size()) ? log_last[i] : 1'b0, i >= 3);
  endtask

  initial begin
    int sum;
    logic [7:0] rdy_or;
    total = 0; bad = 0;
    rst_n = 1'b0; mode = 2'd0; sel = 0; m_rdy = 1'b1;
    phase_b = 1'b0; rand_ctl = 1'b0; prob = 100; rdy_prob = 100;
    clear_prod(); clear_logs(); mdl_reset();

    // Reset state, with a producer already valid.
    add_beat(0, 32'h5A, 1'b1);
    show[0] = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_valid", a_m_valid, 0);
    check_val("rst_m_last", a_m_last, 0);
    check_val("rst_m_data", a_m_data, 0);
    check_val("rst_m_chan", a_m_chan, 0);
    check_val("rst_s_ready", a_s_ready, 0);
    check_val("rst_b_m_valid", b_m_valid, 0);
    finish_reset();

    // Round-robin over all 8 channels, two single-beat packets each.
    mode = 2'd0;
    for (int r = 0; r < 2; r++) for (int k = 0; k < 8; k++) add_beat(k, 32'hA0 + k, 1'b1);
    begin_traffic();
    run_drain(100, "rr8_drain");
    chk_chans("rr8_chan", "012345670");
    for (int i = 0; i < 16; i++)
      check_val("rr8_data", (i < log_dat.size()) ? log_dat[i] : 32'hX, 32'hA0 + (i % 8));

    // Packet lock followed by round-robin and fixed-priority arbitration.
    lock_test(2'd0, "222251");
    lock_test(2'd1, "222215");

    // External select; a select change mid-packet is ignored.
    do_reset();
    mode = 2'd2; sel = 6;
    for (int j = 0; j < 4; j++) add_beat(6, 32'h60 + j, j == 3);
    add_beat(0, 32'h0F, 1'b1);
    begin_traffic();
    run_n(2);
    sel = 0;
    drive();
    run_drain(100, "ext_drain");
    check_val("ext_ready0", log_rdy[0], 8'h40);
    check_val("ext_ready2", log_rdy[2], 8'h40);
    chk_chans("ext_chan", "66660");

    // Random backpressure from three channels.
    do_reset();
    mode = 2'd0; prob = 60; rdy_prob = 50;
    gen_pkts(1, 67); gen_pkts(4, 67); gen_pkts(6, 67);
    begin_traffic();
    run_drain(5000, "bp_drain");
    sum = tail[1] + tail[4] + tail[6];
    check_val("bp_beat_count", log_ch.size(), sum);

    // Random modes/selects on all channels, then asynchronous reset mid-transfer.
    do_reset();
    prob = 50; rdy_prob = 70; rand_ctl = 1'b1;
    for (int c = 0; c < 8; c++) gen_pkts(c, 20);
    begin_traffic();
    run_n(60);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_m_valid", a_m_valid, 0);
    check_val("arst_s_ready", a_s_ready, 0);
    finish_reset();
    mode = 2'd0; prob = 100; rdy_prob = 100;
    for (int k = 0; k < 8; k++) add_beat(k, 32'hC0 + k, 1'b1);
    begin_traffic();
    run_drain(100, "post_rst_drain");
    chk_chans("post_rst_chan", "0");

    // 3-channel, 32-bit instance: round-robin wrap and full-width data.
    phase_b = 1'b1;
    do_reset();
    mode = 2'd0; prob = 100; rdy_prob = 100;
    for (int r = 0; r < 2; r++) for (int k = 0; k < 3; k++) add_beat(k, $urandom, 1'b1);
    begin_traffic();
    run_drain(100, "n3_drain");
    chk_chans("n3_chan", "012012");
    for (int i = 0; i < 6; i++)
      check_val("n3_data", (i < log_dat.size()) ? log_dat[i] : 32'hX, bd[i % 3][i / 3]);

    // Out-of-range select grants nothing.
    do_reset();
    mode = 2'd2; sel = 3;
    for (int k = 0; k < 3; k++) add_beat(k, $urandom, 1'b1);
    begin_traffic();
    run_n(4);
    check_val("oor_out", log_ch.size(), 0);
    rdy_or = '0;
    foreach (log_rdy[i]) rdy_or = rdy_or | log_rdy[i];
    check_val("oor_ready", rdy_or, 0);
    mode = 2'd0;
    drive();
    run_drain(100, "oor_drain");
    chk_chans("oor_chan", "012");

    // Random traffic on the 3-channel instance.
    do_reset();
    prob = 70; rdy_prob = 60; rand_ctl = 1'b1;
    for (int c = 0; c < 3; c++) gen_pkts(c, 40);
    begin_traffic();
    run_drain(5000, "n3_rand_drain");
    check_val("n3_rand_count", log_ch.size(), tail[0] + tail[1] + tail[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
